// File: rtl/fir_filter_param.sv
`default_nettype none
// ============================================================================
// Module   : fir_filter_param
// Purpose  : Parametrised transposed-form FIR filter with valid handshake,
//            double-buffered runtime coefficient reload and synchronous flush.
//            y[n] = sum_{k=0}^{TAPS-1} h[k]*x[n-k], exact in ACC_W bits.
// Ports    : clk         rising-edge clock
//            rst         asynchronous active-low reset (0 = reset)
//            ena         clock enable; low freezes every register
//            sync_clr    flush delay line / outputs, coefficients kept
//            din_valid   x_in carries a new sample
//            x_in        signed sample, DATA_W
//            coef_we     write shadow coefficient
//            coef_addr   shadow tap index (0 = h[0], newest sample)
//            coef_data   signed coefficient, COEF_W
//            coef_commit copy shadow bank to active bank
//            dout_valid  one-cycle pulse per accepted sample
//            dout        signed y[n]; ACC_W wide, or OUT_W with FIR_SAT_OUT_EN
// Options  : FIR_SAT_OUT_EN - round half up after dropping SHIFT LSBs,
//            saturate to OUT_W, one extra register stage (latency 3).
// Revision : 1.0 - initial release
// ============================================================================
module fir_filter_param #(
  parameter int TAPS   = 16,
  parameter int DATA_W = 18,
  parameter int COEF_W = 18,
  parameter int OUT_W  = 18,
  parameter int SHIFT  = 17,
  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS),
  localparam int AW    = $clog2(TAPS),
`ifdef FIR_SAT_OUT_EN
  localparam int DOUT_W = OUT_W
`else
  localparam int DOUT_W = ACC_W
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     sync_clr,
  input  logic                     din_valid,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     coef_commit,
  output logic                     dout_valid,
  output logic signed [DOUT_W-1:0] dout
);

  localparam int PROD_W = DATA_W + COEF_W;

  // Elaboration guard on the parameter set.
  if (TAPS < 2 || SHIFT < 1 || SHIFT >= ACC_W - OUT_W + 1) begin : g_bad_params
    $error("fir_filter_param: illegal TAPS/SHIFT/OUT_W combination");
  end

  // --------------------------------------------------------------------------
  // Coefficient banks
  // --------------------------------------------------------------------------
  logic signed [COEF_W-1:0] shadow_q [TAPS];
  logic signed [COEF_W-1:0] shadow_d [TAPS];
  logic signed [COEF_W-1:0] active_q [TAPS];

  // The commit copies shadow_d so a write in the same cycle is included.
  always_comb begin
    shadow_d = shadow_q;
    if (coef_we && ({1'b0, coef_addr} < (AW+1)'(TAPS))) begin
      shadow_d[coef_addr] = coef_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else if (ena) begin
      shadow_q <= shadow_d;
      if (coef_commit) begin
        active_q <= shadow_d;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: input register, transposed partial-sum chain
  // --------------------------------------------------------------------------
  logic signed [DATA_W-1:0] x_q;
  logic                     x_vld_q;
  logic signed [ACC_W-1:0]  p_q [TAPS];
  logic signed [ACC_W-1:0]  p_d [TAPS];
  logic                     p_vld_q;
  logic signed [DOUT_W-1:0] out_val_w;
  logic                     out_vld_w;
  logic signed [DOUT_W-1:0] dout_q;
  logic                     dout_valid_q;

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    logic signed [PROD_W-1:0] prod_w;
    logic signed [ACC_W-1:0]  carry_w;

    assign prod_w = x_q * active_q[k];

    // The oldest tap has no upstream partial sum.
    if (k == TAPS - 1) begin : g_last
      assign carry_w = '0;
    end else begin : g_mid
      assign carry_w = p_q[k+1];
    end

    assign p_d[k] = {{(ACC_W-PROD_W){prod_w[PROD_W-1]}}, prod_w} + carry_w;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q     <= '0;
      x_vld_q <= 1'b0;
      p_vld_q <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        p_q[k] <= '0;
      end
    end else if (ena) begin
      if (sync_clr) begin
        x_q     <= '0;
        x_vld_q <= 1'b0;
        p_vld_q <= 1'b0;
        for (int k = 0; k < TAPS; k++) begin
          p_q[k] <= '0;
        end
      end else begin
        x_vld_q <= din_valid;
        if (din_valid) begin
          x_q <= x_in;
        end
        // The chain only shifts on real samples so input gaps lose nothing.
        p_vld_q <= x_vld_q;
        if (x_vld_q) begin
          p_q <= p_d;
        end
      end
    end
  end

`ifdef FIR_SAT_OUT_EN
  // --------------------------------------------------------------------------
  // Round half up, then saturate to OUT_W, registered
  // --------------------------------------------------------------------------
  localparam logic signed [ACC_W:0] HALF =
    {{(ACC_W+1-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};

  logic signed [ACC_W:0]    rnd_sum_w;
  logic signed [ACC_W:0]    rnd_w;
  logic signed [OUT_W-1:0]  sat_d;
  logic signed [OUT_W-1:0]  sat_q;
  logic                     sat_vld_q;

  // One guard bit keeps the rounding add from wrapping.
  assign rnd_sum_w = {p_q[0][ACC_W-1], p_q[0]} + HALF;
  assign rnd_w     = rnd_sum_w >>> SHIFT;

  always_comb begin
    sat_d = rnd_w[OUT_W-1:0];
    if (rnd_w[ACC_W:OUT_W-1] != {(ACC_W-OUT_W+2){rnd_w[ACC_W]}}) begin
      sat_d = rnd_w[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                           : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_q     <= '0;
      sat_vld_q <= 1'b0;
    end else if (ena) begin
      if (sync_clr) begin
        sat_q     <= '0;
        sat_vld_q <= 1'b0;
      end else begin
        sat_vld_q <= p_vld_q;
        if (p_vld_q) begin
          sat_q <= sat_d;
        end
      end
    end
  end

  assign out_val_w = sat_q;
  assign out_vld_w = sat_vld_q;
`else
  assign out_val_w = p_q[0];
  assign out_vld_w = p_vld_q;
`endif

  // --------------------------------------------------------------------------
  // Output register: dout holds its last value between valid pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else if (ena) begin
      if (sync_clr) begin
        dout_q       <= '0;
        dout_valid_q <= 1'b0;
      end else begin
        dout_valid_q <= out_vld_w;
        if (out_vld_w) begin
          dout_q <= out_val_w;
        end
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_filter_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_filter_param
// Purpose  : Self-checking bench for fir_filter_param. A history-based
//            reference model (sum over stored samples and the coefficient
//            set each sample was multiplied with) predicts every output;
//            directed tables and sequences cover impulse, stall, coefficient
//            swap, flush, reset and (with FIR_SAT_OUT_EN) saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_filter_param;

  localparam int TAPS   = 16;
  localparam int DATA_W = 18;
  localparam int COEF_W = 18;
  localparam int OUT_W  = 18;
  localparam int SHIFT  = 17;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam int AW     = $clog2(TAPS);
`ifdef FIR_SAT_OUT_EN
  localparam int DOUT_W = OUT_W;
  localparam int LAT    = 3;
`else
  localparam int DOUT_W = ACC_W;
  localparam int LAT    = 2;
`endif

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     ena = 1'b0;
  logic                     sync_clr = 1'b0;
  logic                     din_valid = 1'b0;
  logic signed [DATA_W-1:0] x_in = '0;
  logic                     coef_we = 1'b0;
  logic [AW-1:0]            coef_addr = '0;
  logic signed [COEF_W-1:0] coef_data = '0;
  logic                     coef_commit = 1'b0;
  logic                     dout_valid;
  logic signed [DOUT_W-1:0] dout;

  always #5 clk = ~clk;

  fir_filter_param #(
    .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .sync_clr(sync_clr), .din_valid(din_valid),
    .x_in(x_in), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_commit(coef_commit), .dout_valid(dout_valid), .dout(dout)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  typedef struct {
    longint x;
    longint h[TAPS];
  } hist_t;

  hist_t  hist[$];
  longint h_act[TAPS];
  longint h_sh[TAPS];
  logic   pv[LAT];
  longint py[LAT];
  logic   exp_valid;
  longint exp_dout;
  longint got[$];
  int     out_cnt;

  function automatic longint fmt(input longint y);
`ifdef FIR_SAT_OUT_EN
    longint r;
    longint mx;
    longint mn;
    r  = (y + (longint'(1) <<< (SHIFT-1))) >>> SHIFT;
    mx = (longint'(1) <<< (OUT_W-1)) - 1;
    mn = -(longint'(1) <<< (OUT_W-1));
    if (r > mx) r = mx;
    if (r < mn) r = mn;
    return r;
`else
    return y;
`endif
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < TAPS; k++) begin
      h_act[k] = 0;
      h_sh[k]  = 0;
    end
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      py[i] = 0;
    end
    exp_valid = 1'b0;
    exp_dout  = 0;
  endtask

  // Called right after each rising edge with the inputs that edge saw.
  task automatic model_edge();
    hist_t  e;
    longint y;
    int     n;
    if (!rst || !ena) return;
    if (coef_we && int'(coef_addr) < TAPS) h_sh[coef_addr] = longint'(coef_data);
    if (coef_commit) h_act = h_sh;
    if (sync_clr) begin
      hist.delete();
      for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
      exp_valid = 1'b0;
      exp_dout  = 0;
      return;
    end
    exp_valid = pv[LAT-1];
    if (pv[LAT-1]) exp_dout = py[LAT-1];
    for (int i = LAT-1; i > 0; i--) begin
      pv[i] = pv[i-1];
      py[i] = py[i-1];
    end
    pv[0] = 1'b0;
    if (din_valid) begin
      // A sample is multiplied by the bank that is active after its accept edge.
      e.x = longint'(x_in);
      e.h = h_act;
      hist.push_back(e);
      while (hist.size() > TAPS) void'(hist.pop_front());
      n = hist.size();
      y = 0;
      for (int k = 0; k < n; k++) y += hist[n-1-k].x * hist[n-1-k].h[k];
      pv[0] = 1'b1;
      py[0] = fmt(y);
    end
  endtask

  task automatic cycle();
    logic en_edge;
    @(posedge clk);
    model_edge();
    en_edge = ena && rst;
    #1;
    chk("dout_valid", longint'(dout_valid), longint'(exp_valid));
    chk("dout", longint'(dout), exp_dout);
    if (en_edge && dout_valid) begin
      out_cnt++;
      got.push_back(longint'(dout));
    end
  endtask

  task automatic write_coef(input int addr, input longint val, input bit commit);
    coef_we     = 1'b1;
    coef_addr   = AW'(addr);
    coef_data   = COEF_W'(val);
    coef_commit = commit;
    cycle();
    coef_we     = 1'b0;
    coef_commit = 1'b0;
  endtask

  task automatic feed(input longint x, input int count);
    din_valid = 1'b1;
    x_in      = DATA_W'(x);
    repeat (count) cycle();
    din_valid = 1'b0;
    repeat (LAT + 1) cycle();
  endtask

  typedef struct {
    logic signed [DATA_W-1:0] x;
    logic                     v;
    logic                     ev;
    longint                   ed;
  } vec_t;

  vec_t tbl[20];

  initial begin
    model_reset();
    out_cnt = 0;

    // ---- Reset state ------------------------------------------------------
    ena = 1'b1;
    repeat (2) cycle();
    chk("reset_dout", longint'(dout), 0);
    chk("reset_valid", longint'(dout_valid), 0);
    rst = 1'b1;
    repeat (2) cycle();

    // ---- Impulse response, h[k] = k+1 (last write shares the commit) ------
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1, k == TAPS - 1);
    for (int i = 0; i < 20; i++) begin
      tbl[i].x  = (i == 0) ? 18'sd1000 : 18'sd0;
      tbl[i].v  = 1'b1;
      tbl[i].ev = (i >= LAT);
      tbl[i].ed = (i < LAT) ? 0 : ((i - LAT < TAPS) ? fmt(1000 * (i - LAT + 1)) : fmt(0));
    end
    for (int i = 0; i < 20; i++) begin
      x_in      = tbl[i].x;
      din_valid = tbl[i].v;
      cycle();
      chk("impulse_valid", longint'(dout_valid), longint'(tbl[i].ev));
      chk("impulse_dout", longint'(dout), tbl[i].ed);
    end
    din_valid = 1'b0;
    repeat (LAT + 1) cycle();

    // ---- Stall: din_valid gaps and ena pulses -----------------------------
    begin
      int sent;
      int cyc;
      sent = 0;
      cyc  = 0;
      got.delete();
      out_cnt = 0;
      while (sent < 20) begin
        ena       = (cyc % 5) != 3;
        din_valid = (cyc % 2) == 0;
        x_in      = (sent == 0) ? 18'sd1000 : 18'sd0;
        cycle();
        if (ena && din_valid) sent++;
        cyc++;
      end
      ena       = 1'b1;
      din_valid = 1'b0;
      repeat (LAT + 2) cycle();
      chk("stall_count", out_cnt, sent);
      for (int i = 0; i < 20 && i < got.size(); i++)
        chk("stall_seq", got[i], (i < TAPS) ? fmt(1000 * (i + 1)) : fmt(0));
    end

    // ---- Coefficient swap -------------------------------------------------
    for (int k = 0; k < TAPS; k++) write_coef(k, 1, k == TAPS - 1);
    got.delete();
    feed(5, 20);
    chk("steady_80", got[got.size()-1], fmt(80));
    for (int k = 0; k < TAPS; k++) write_coef(k, 2, k == TAPS - 1);
    got.delete();
    feed(5, 20);
    for (int i = 0; i < 20; i++)
      chk("swap_ramp", got[i], fmt((85 + 5 * i > 160) ? 160 : 85 + 5 * i));
    for (int k = 0; k < TAPS; k++) write_coef(k, 7, 1'b0);
    got.delete();
    feed(5, 5);
    chk("uncommitted", got[got.size()-1], fmt(160));

    // ---- Flush during steady input ----------------------------------------
    din_valid = 1'b1;
    x_in      = 18'sd5;
    repeat (10) cycle();
    sync_clr = 1'b1;
    cycle();
    sync_clr = 1'b0;
    chk("flush_dout", longint'(dout), 0);
    chk("flush_valid", longint'(dout_valid), 0);
    got.delete();
    feed(5, 20);
    for (int i = 0; i < 20; i++)
      chk("flush_ramp", got[i], fmt((10 * (i + 1) > 160) ? 160 : 10 * (i + 1)));

    // ---- Randomised traffic against the model -----------------------------
    for (int i = 0; i < 600; i++) begin
      ena         = ($urandom % 8) != 0;
      din_valid   = ($urandom % 3) != 0;
      x_in        = DATA_W'($urandom);
      coef_we     = ($urandom % 6) == 0;
      coef_addr   = AW'($urandom);
      coef_data   = COEF_W'($urandom);
      coef_commit = ($urandom % 40) == 0;
      sync_clr    = ($urandom % 60) == 0;
      cycle();
    end
    ena = 1'b1; sync_clr = 1'b0; coef_we = 1'b0; coef_commit = 1'b0;

    // ---- Reset mid-operation ----------------------------------------------
    din_valid = 1'b1;
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1, k == TAPS - 1);
    repeat (5) begin
      x_in = DATA_W'($urandom_range(1, 5000));
      cycle();
    end
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_dout", longint'(dout), 0);
    chk("async_rst_valid", longint'(dout_valid), 0);
    repeat (2) cycle();
    rst       = 1'b1;
    din_valid = 1'b0;
    repeat (3) cycle();
    chk("post_rst_valid", longint'(dout_valid), 0);
    feed(1234, 3);
    chk("zero_coef_out", longint'(dout), 0);

`ifdef FIR_SAT_OUT_EN
    // ---- Saturation and rounding ------------------------------------------
    for (int k = 0; k < TAPS; k++) write_coef(k, 131071, k == TAPS - 1);
    got.delete();
    feed(131071, 20);
    chk("sat_pos", got[got.size()-1], 131071);
    got.delete();
    feed(-131072, 20);
    chk("sat_neg", got[got.size()-1], -131072);
    for (int k = 0; k < TAPS; k++) write_coef(k, (k == 0) ? 65536 : 0, k == TAPS - 1);
    feed(0, TAPS);
    got.delete();
    feed(1, 1);
    chk("round_half_up", got[got.size()-1], 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
